// File: rtl/half_adder_checker_if.sv
// Stimulus/response bus between the checker and the half adder under test.
// The checker drives the operands; the adder returns sum and carry.
interface half_adder_checker_if;
    logic a_o;
    logic b_o;
    logic sum_i;
    logic carry_i;

    modport master (
        output a_o,
        output b_o,
        input  sum_i,
        input  carry_i
    );

    modport slave (
        input  a_o,
        input  b_o,
        output sum_i,
        output carry_i
    );
endinterface

// File: rtl/half_adder_checker.sv
// Exhaustive stimulus/response checker for a combinational 1-bit half adder.
// Steps {a,b} through 00,01,10,11, holds each vector HOLD_CYCLES cycles,
// compares the returned sum/carry on the last hold cycle and reports a summary.
module half_adder_checker #(
    parameter int HOLD_CYCLES = 10,
    parameter int ERR_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
    half_adder_checker_if.master  bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [3:0]            fail_vec,
    output logic [1:0]            first_idx,
    output logic [1:0]            first_got
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]    HLAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg;
    logic [1:0]     idx_reg;
    logic [HW-1:0]  hcnt_reg;
    // Low during the first RUN cycle, which only loads vector 00 onto the bus;
    // the hold count starts once the operands are actually driven.
    logic           armed_reg;

    logic           exp_sum;
    logic           exp_carry;
    logic           mismatch;
    logic [1:0]     idx_next;
    logic [ERR_W-1:0] err_next;
    logic [3:0]     idx_hot;

    // Golden model and compare against the operands currently on the bus.
    always_comb begin
        exp_sum   = bus.a_o ^ bus.b_o;
        exp_carry = bus.a_o & bus.b_o;
        mismatch  = (bus.sum_i != exp_sum) || (bus.carry_i != exp_carry);
        idx_next  = idx_reg + 2'd1;
        err_next  = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;
    end

    // One-hot decode of the current vector index for the fail flags.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hot
            assign idx_hot[gi] = (idx_reg == 2'(gi));
        end
    endgenerate

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= 2'd0;
            hcnt_reg  <= '0;
            armed_reg <= 1'b0;
            bus.a_o   <= 1'b0;
            bus.b_o   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= 4'd0;
            first_idx <= 2'd0;
            first_got <= 2'd0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg <= RUN;
                        idx_reg   <= 2'd0;
                        hcnt_reg  <= '0;
                        armed_reg <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_vec  <= 4'd0;
                        first_idx <= 2'd0;
                        first_got <= 2'd0;
                    end
                end
                RUN: begin
                    if (!armed_reg) begin
                        armed_reg <= 1'b1;
                        bus.a_o   <= idx_reg[1];
                        bus.b_o   <= idx_reg[0];
                    end else if (hcnt_reg != HLAST) begin
                        hcnt_reg <= hcnt_reg + 1'b1;
                    end else begin
                        hcnt_reg <= '0;
                        idx_reg  <= idx_next;
                        if (mismatch) begin
                            err_count <= err_next;
                            fail_vec  <= fail_vec | idx_hot;
                            if (err_count == '0) begin
                                first_idx <= idx_reg;
                                first_got <= {bus.carry_i, bus.sum_i};
                            end
                        end
                        if (idx_reg == 2'd3 && !continuous) begin
                            // Operands keep showing the last vector in DONE.
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= !mismatch && (err_count == '0);
                        end else begin
                            bus.a_o <= idx_next[1];
                            bus.b_o <= idx_next[0];
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_half_adder_checker.sv
// Directed bench for half_adder_checker with behavioural fault models of the adder.
module tb_half_adder_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic start10 = 1'b0, cont10 = 1'b0;
    logic start1 = 1'b0, cont1 = 1'b0;
    logic startsat = 1'b0, contsat = 1'b0;
    int   m10 = 0, m1 = 0, msat = 0;

    int checks = 0;
    int errors = 0;

    // Adder models: 0 ideal, 1 carry stuck 0, 2 sum inverted, 3 sum stuck 1. Returns {carry,sum}.
    function automatic logic [1:0] adder(input logic a, input logic b, input int mode);
        case (mode)
            1:       return {1'b0, a ^ b};
            2:       return {a & b, ~(a ^ b)};
            3:       return {a & b, 1'b1};
            default: return {a & b, a ^ b};
        endcase
    endfunction

    // H=10 instance
    half_adder_checker_if if10();
    logic busy10, done10, pass10;
    logic [7:0] err10;
    logic [3:0] fv10;
    logic [1:0] fi10, fg10;
    assign {if10.carry_i, if10.sum_i} = adder(if10.a_o, if10.b_o, m10);
    half_adder_checker #(.HOLD_CYCLES(10), .ERR_W(8)) u10 (
        .clk(clk), .reset(reset), .start(start10), .continuous(cont10), .bus(if10),
        .busy(busy10), .done(done10), .pass(pass10), .err_count(err10),
        .fail_vec(fv10), .first_idx(fi10), .first_got(fg10));

    // H=1 instance
    half_adder_checker_if if1();
    logic busy1, done1, pass1;
    logic [7:0] err1;
    logic [3:0] fv1;
    logic [1:0] fi1, fg1;
    assign {if1.carry_i, if1.sum_i} = adder(if1.a_o, if1.b_o, m1);
    half_adder_checker #(.HOLD_CYCLES(1), .ERR_W(8)) u1 (
        .clk(clk), .reset(reset), .start(start1), .continuous(cont1), .bus(if1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_vec(fv1), .first_idx(fi1), .first_got(fg1));

    // H=1, 2-bit error counter for saturation
    half_adder_checker_if ifsat();
    logic busysat, donesat, passsat;
    logic [1:0] errsat;
    logic [3:0] fvsat;
    logic [1:0] fisat, fgsat;
    assign {ifsat.carry_i, ifsat.sum_i} = adder(ifsat.a_o, ifsat.b_o, msat);
    half_adder_checker #(.HOLD_CYCLES(1), .ERR_W(2)) usat (
        .clk(clk), .reset(reset), .start(startsat), .continuous(contsat), .bus(ifsat),
        .busy(busysat), .done(donesat), .pass(passsat), .err_count(errsat),
        .fail_vec(fvsat), .first_idx(fisat), .first_got(fgsat));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic chk_zero10(input string tag);
        chk({tag, "_busy"}, busy10, 0);
        chk({tag, "_done"}, done10, 0);
        chk({tag, "_pass"}, pass10, 0);
        chk({tag, "_err"}, err10, 0);
        chk({tag, "_fv"}, fv10, 0);
        chk({tag, "_first"}, {fi10, fg10}, 0);
        chk({tag, "_ab"}, {if10.a_o, if10.b_o}, 0);
    endtask

    // Start a run on the H=10 instance; optionally re-pulse start at edge N+repulse_at.
    task automatic run10(input int repulse_at, output int done_at);
        int k;
        @(negedge clk) start10 = 1'b1;
        @(posedge clk); #1;
        chk("run_busy_entry", busy10, 1);
        k = 0;
        while (k < 200 && done10 !== 1'b1) begin
            @(negedge clk) start10 = (k + 1 == repulse_at);
            @(posedge clk); #1;
            k++;
            if (k == 1 || k == 11 || k == 21 || k == 31)
                chk("run_vector", {if10.a_o, if10.b_o}, (k - 1) / 10);
        end
        @(negedge clk) start10 = 1'b0;
        done_at = k;
    endtask

    typedef struct {
        int         mode;
        logic [7:0] err;
        logic [3:0] fv;
        logic [1:0] fi;
        logic [1:0] fg;
        logic       ps;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int   d;
        int   k;
        logic busy_ok;

        tbl[0] = '{0, 8'd0, 4'b0000, 2'd0, 2'b00, 1'b1};  // ideal
        tbl[1] = '{1, 8'd1, 4'b1000, 2'd3, 2'b00, 1'b0};  // carry stuck 0
        tbl[2] = '{2, 8'd4, 4'b1111, 2'd0, 2'b01, 1'b0};  // sum inverted
        tbl[3] = '{3, 8'd2, 4'b1001, 2'd0, 2'b01, 1'b0};  // sum stuck 1
        tbl[4] = '{0, 8'd0, 4'b0000, 2'd0, 2'b00, 1'b1};  // ideal after faults: clear check

        repeat (3) @(posedge clk);
        #1;
        chk_zero10("reset");
        chk("reset_busy1", busy1, 0);
        @(negedge clk) reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", busy10, 0);

        for (int i = 0; i < 5; i++) begin
            m10 = tbl[i].mode;
            run10(0, d);
            chk("done_cycle", d, 41);
            chk("pass", pass10, tbl[i].ps);
            chk("err_count", err10, tbl[i].err);
            chk("fail_vec", fv10, tbl[i].fv);
            chk("first_idx", fi10, tbl[i].fi);
            chk("first_got", fg10, tbl[i].fg);
            chk("done_busy", busy10, 0);
            chk("done_hold_ab", {if10.a_o, if10.b_o}, 3);
            $display("run %0d mode=%0d done_at=%0d err=%0d fail_vec=%b pass=%0b",
                     i, tbl[i].mode, d, err10, fv10, pass10);
        end

        // start re-pulsed while busy
        m10 = 0;
        run10(15, d);
        chk("repulse_done_cycle", d, 41);
        chk("repulse_pass", pass10, 1);
        $display("repulse run done_at=%0d pass=%0b", d, pass10);

        // reset mid-run
        m10 = 2;
        @(negedge clk) start10 = 1'b1;
        @(posedge clk);
        @(negedge clk) start10 = 1'b0;
        repeat (24) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk_zero10("midreset");
        @(negedge clk) reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midreset_idle", busy10, 0);
        m10 = 0;
        run10(0, d);
        chk("after_reset_done", d, 41);
        chk("after_reset_pass", pass10, 1);
        $display("reset recovery run done_at=%0d pass=%0b", d, pass10);

        // HOLD_CYCLES=1, continuous, sum stuck 1, three runs
        m1 = 3;
        cont1 = 1'b1;
        @(negedge clk) start1 = 1'b1;
        @(posedge clk); #1;
        busy_ok = 1'b1;
        k = 0;
        while (k < 60 && done1 !== 1'b1) begin
            @(negedge clk) begin
                start1 = 1'b0;
                if (k == 10) cont1 = 1'b0;
            end
            @(posedge clk); #1;
            k++;
            if (done1 !== 1'b1 && busy1 !== 1'b1) busy_ok = 1'b0;
        end
        chk("cont_busy_held", busy_ok, 1);
        chk("cont_done_cycle", k, 13);
        chk("cont_err", err1, 6);
        chk("cont_fail_vec", fv1, 4'b1001);
        chk("cont_first_idx", fi1, 0);
        chk("cont_first_got", fg1, 2'b01);
        chk("cont_pass", pass1, 0);
        $display("continuous H=1 done_at=%0d err=%0d fail_vec=%b", k, err1, fv1);

        // saturation on a 2-bit counter: 8 mismatches over two runs
        msat = 2;
        contsat = 1'b1;
        @(negedge clk) startsat = 1'b1;
        @(posedge clk); #1;
        k = 0;
        while (k < 60 && donesat !== 1'b1) begin
            @(negedge clk) begin
                startsat = 1'b0;
                if (k == 6) contsat = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        chk("sat_done_cycle", k, 9);
        chk("sat_err", errsat, 3);
        chk("sat_fail_vec", fvsat, 4'b1111);
        chk("sat_pass", passsat, 0);
        $display("saturation done_at=%0d err=%0d", k, errsat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
